spi_slave_tx_buffer: RTL and testbench

SPI_SLAVE_TX_BUFFER -- requirements
Module: spi_slave_tx_buffer

---
 rtl/spi_slave_tx_buffer.sv | 88 ++++++++
 tb/tb_spi_slave_tx_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_tx_buffer.sv
// Transmit-side word FIFO between the AXI register plug and the SPI shift path.
// Optional macro SPI_TXBUF_STATS_EN compiles in the saturating words_sent counter.
module spi_slave_tx_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic                    cs,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             words_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;

  // The extra pointer MSB separates a wrapped-full FIFO from an empty one.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign in_ready  = !full && !cs;
  assign out_valid = !empty && !cs;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (cs) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      case ({push, pop})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage is cleared on reset so out_data reads zero until the first push.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

`ifdef SPI_TXBUF_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] sent_cnt;

  // Counts delivered words; a flush via cs deliberately leaves it untouched.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)  sent_cnt <= '0;
    else if (pop)      sent_cnt <= sat_inc(sent_cnt);
  end

  assign words_sent = sent_cnt;
`else
  assign words_sent = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_slave_tx_buffer.sv
// Scoreboard bench for spi_slave_tx_buffer: driver queues accepted words, monitor checks deliveries.
`timescale 1ns/1ps
module tb_spi_slave_tx_buffer;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    level;
  logic [15:0]   words_sent;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] sb [$];
  logic [15:0]   ws_model = 16'h0;

  always #5 clk = ~clk;

  spi_slave_tx_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n), .cs(cs),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .words_sent(words_sent)
  );

  function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: consumes the expected-word queue on every delivered word.
  always @(negedge clk) begin
    if (rst_n) begin
      check("words_sent", DW'(words_sent), DW'(ws_model));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", out_data, 32'hDEAD_DEAD);
        end else begin
          check("out_data_order", out_data, sb.pop_front());
        end
`ifdef SPI_TXBUF_STATS_EN
        if (ws_model != 16'hFFFF) ws_model = ws_model + 16'd1;
`endif
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic c);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    cs        = c;
    @(negedge clk);
    if (cs) sb.delete();
    else if (in_valid && in_ready) sb.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] w;
    #2;
    check("rst_out_valid", DW'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_level", DW'(level), 0);
    check("rst_words_sent", DW'(words_sent), 0);
    check("rst_in_ready", DW'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single word latency
    step(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
    check("lat_level1", DW'(level), 1);
    check("lat_valid", DW'(out_valid), 1);
    check("lat_data", out_data, 32'hA5A5_0001);
    drain(1);
    check("lat_level0", DW'(level), 0);
    check("lat_empty", DW'(out_valid), 0);

    // fill to full, then drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    check("full_level", DW'(level), 4);
    check("full_in_ready", DW'(in_ready), 0);
    step(1'b1, 32'h5, 1'b0, 1'b0);
    check("held_level", DW'(level), 4);
    check("held_data", out_data, 32'h1);
    out_ready = 1'b1;
    #1;
    check("full_rdy_indep", DW'(in_ready), 0);
    step(1'b1, 32'h5, 1'b1, 1'b0);
    check("after_pop_level", DW'(level), 3);
    check("after_pop_in_ready", DW'(in_ready), 1);
    step(1'b1, 32'h5, 1'b1, 1'b0);
    check("fifth_level", DW'(level), 3);
    drain(3);
    check("drain_level", DW'(level), 0);

    // simultaneous push and pop at level 2
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    check("lvl2", DW'(level), 2);
    step(1'b1, 32'h33, 1'b1, 1'b0);
    check("pushpop_level", DW'(level), 2);
    drain(2);
    check("pushpop_drain", DW'(level), 0);

    // 20 words across pointer wrap with irregular handshakes
    begin
      int sent = 0;
      for (int c = 0; c < 200 && sent < 20; c++) begin
        logic iv;
        iv = 1'($urandom_range(0, 1));
        w  = $urandom;
        if (iv && in_ready) sent++;
        step(iv, w, 1'($urandom_range(0, 1)), 1'b0);
      end
      check("wrap_sent", DW'(sent), 20);
    end
    drain(6);
    check("wrap_level", DW'(level), 0);
    check("wrap_sb_empty", DW'(sb.size()), 0);

    // cs flush at level 3
    for (int i = 0; i < 3; i++) step(1'b1, DW'(32'hC0 + i), 1'b0, 1'b0);
    check("cs_pre_level", DW'(level), 3);
    cs = 1'b1;
    #1;
    check("cs_out_valid", DW'(out_valid), 0);
    check("cs_in_ready", DW'(in_ready), 0);
    step(1'b1, 32'hFFFF_0000, 1'b1, 1'b1);
    cs = 1'b0;
    in_valid = 1'b0;
    #1;
    check("cs_level", DW'(level), 0);
    check("cs_post_valid", DW'(out_valid), 0);
    step(1'b1, 32'h0000_BEEF, 1'b0, 1'b0);
    check("beef_valid", DW'(out_valid), 1);
    check("beef_data", out_data, 32'h0000_BEEF);
    drain(1);

    // asynchronous reset with level 3
    for (int i = 0; i < 3; i++) step(1'b1, DW'(32'hD0 + i), 1'b0, 1'b0);
    check("rst2_pre_level", DW'(level), 3);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    sb.delete();
    ws_model = 16'h0;
    #1;
    check("rst2_out_valid", DW'(out_valid), 0);
    check("rst2_out_data", out_data, 0);
    check("rst2_level", DW'(level), 0);
    check("rst2_words_sent", DW'(words_sent), 0);
    check("rst2_in_ready", DW'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    check("rst2_first_valid", DW'(out_valid), 1);
    check("rst2_first_data", out_data, 32'h1234_5678);
    drain(1);

`ifdef SPI_TXBUF_STATS_EN
    for (int i = 0; i < 65540; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
    drain(1);
    check("stats_saturated", DW'(words_sent), 32'hFFFF);
`else
    for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
    drain(1);
    check("stats_tied_zero", DW'(words_sent), 0);
`endif
    check("final_sb_empty", DW'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
